// File: rtl/dp_ram_param.sv
// rtl/dp_ram_param.sv - parametrised true dual-port byte-enabled RAM
// Post-reset clear sequencer, optional output register, per-port read-during-write mode, collision tracking.
module dp_ram_param #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int OUT_REG        = 0,
    parameter int WRITE_FIRST    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    init_done_o,
    input  logic                    en_a_i,
    input  logic [ADDR_WIDTH-1:0]   addr_a_i,
    input  logic [DATA_WIDTH-1:0]   wdata_a_i,
    input  logic                    we_a_i,
    input  logic [DATA_WIDTH/8-1:0] be_a_i,
    output logic [DATA_WIDTH-1:0]   rdata_a_o,
    output logic                    rvalid_a_o,
    input  logic                    en_b_i,
    input  logic [ADDR_WIDTH-1:0]   addr_b_i,
    input  logic [DATA_WIDTH-1:0]   wdata_b_i,
    input  logic                    we_b_i,
    input  logic [DATA_WIDTH/8-1:0] be_b_i,
    output logic [DATA_WIDTH-1:0]   rdata_b_o,
    output logic                    rvalid_b_o,
    output logic                    collision_o,
    output logic [15:0]             coll_cnt_o
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    init_done_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    acc_a, acc_b, wr_a, wr_b, coll;
    logic [DATA_WIDTH-1:0]   old_a, old_b, rd_a, rd_b;
    logic [1:0]              v1_q;
    logic [DATA_WIDTH-1:0]   d1_q [2];
    logic                    coll_q;
    logic [15:0]             coll_cnt_q;

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                    input logic [DATA_WIDTH-1:0] new_w,
                                                    input logic [BE_W-1:0]       be);
        merge = old_w;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) merge[8*i +: 8] = new_w[8*i +: 8];
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (&clr_cnt_q) state_d = READY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= (state_d == READY);
        end
    end

    assign init_done_o = init_done_q;
    assign acc_a = rst_n & init_done_q & en_a_i;
    assign acc_b = rst_n & init_done_q & en_b_i;
    assign wr_a  = acc_a & we_a_i;
    assign wr_b  = acc_b & we_b_i;
    assign coll  = acc_a & acc_b & (addr_a_i == addr_b_i) & (we_a_i | we_b_i);

    // Port B lanes are written first so port A wins any lane both ports enable.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_b && be_b_i[i]) mem_q[addr_b_i][8*i +: 8] <= wdata_b_i[8*i +: 8];
                if (wr_a && be_a_i[i]) mem_q[addr_a_i][8*i +: 8] <= wdata_a_i[8*i +: 8];
            end
        end
    end

    // The other port's same-cycle write is never forwarded; only the own-port write is.
    assign old_a = mem_q[addr_a_i];
    assign old_b = mem_q[addr_b_i];
    assign rd_a  = (WRITE_FIRST != 0 && we_a_i) ? merge(old_a, wdata_a_i, be_a_i) : old_a;
    assign rd_b  = (WRITE_FIRST != 0 && we_b_i) ? merge(old_b, wdata_b_i, be_b_i) : old_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q       <= '0;
            d1_q[0]    <= '0;
            d1_q[1]    <= '0;
            coll_q     <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            v1_q <= {acc_b, acc_a};
            if (acc_a) d1_q[0] <= rd_a;
            if (acc_b) d1_q[1] <= rd_b;
            coll_q <= coll;
            if (coll && coll_cnt_q != 16'hFFFF) coll_cnt_q <= coll_cnt_q + 16'd1;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [1:0]            v2_q;
            logic [DATA_WIDTH-1:0] d2_q [2];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v2_q    <= '0;
                    d2_q[0] <= '0;
                    d2_q[1] <= '0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q[0]) d2_q[0] <= d1_q[0];
                    if (v1_q[1]) d2_q[1] <= d1_q[1];
                end
            end
            assign rvalid_a_o = v2_q[0];
            assign rvalid_b_o = v2_q[1];
            assign rdata_a_o  = d2_q[0];
            assign rdata_b_o  = d2_q[1];
        end else begin : g_noreg
            assign rvalid_a_o = v1_q[0];
            assign rvalid_b_o = v1_q[1];
            assign rdata_a_o  = d1_q[0];
            assign rdata_b_o  = d1_q[1];
        end
    endgenerate

    assign collision_o = coll_q;
    assign coll_cnt_o  = coll_cnt_q;
endmodule
